multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath, replacing single-cycle decode when the core shares one memory port for instruction and data.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states.
- Drives PC, IR, memory, ALU and register-file enables per state.
- Waits on a memory ready handshake and traps hung accesses.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready before fault; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; stable outside FETCH
- funct  in  6  IR[5:0]; stable outside FETCH
- mem_ready  in  1  memory completed current read/write this cycle
- alu_zero  in  1  ALU result equals zero
- pc_write  out  1  load PC this cycle
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs register
- ir_write  out  1  load IR from memory read data
- i_or_d  out  1  memory address select: 0=PC, 1=ALU result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ALUOp  out  4  1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 slt, 8 sll, 9 srl, 10 beq, 11 bne, 0 idle
- Reg_imm  out  1  ALU B source: 0=register, 1=sign-extended immediate
- RegWrite  out  1  register file write enable
- MemtoReg  out  1  write-back source: 1=memory data register
- Jal  out  1  write-back target $31 / data PC
- Half  out  1  halfword access
- illegal  out  1  one-cycle pulse on undecodable instruction
- fault  out  1  sticky, memory timeout occurred
- state  out  4  current state encoding (debug)

Behaviour:
- Reset
  - Reset is synchronous and active-high: a rising clk edge with rst=1 sets state=FETCH and clears the wait counter, latched class and fault.
  - While rst=1, all outputs are forced to 0.
- Output timing: outputs are combinational from current state, latched class, mem_ready and alu_zero. Any output not listed for a state is 0.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, WB_ALU=3, ADDR=4, MEM_RD=5, WB_MEM=6, MEM_WR=7, BRANCH=8, JUMP=9, JREG=10, FAULT=15.
- FETCH
  - mem_read=1, i_or_d=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE
  - Latch instruction class from opcode/funct. Classes: R-ALU, I-ALU, load, store, branch, j, jal, jr, jalr.
  - Opcode/funct mapping is identical to the existing single-cycle controller.
  - R-ALU or I-ALU -> EXEC; lw/lh/sw/sh -> ADDR; beq/bne -> BRANCH; j/jal -> JUMP; jr/jalr -> JREG.
  - Unknown opcode or R-type funct: illegal=1, go to FETCH; PC is already advanced.
- EXEC: ALUOp per instruction. Reg_imm=1 for addi/andi/slti, 0 for R-type. Go to WB_ALU.
- WB_ALU: RegWrite=1; ALUOp and Reg_imm held from EXEC. Go to FETCH.
- ADDR: ALUOp=add, Reg_imm=1. Go to MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read=1, i_or_d=1, Half for lh. On mem_ready go to WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1, Half for lh. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1, Half for sh. On mem_ready go to FETCH.
- BRANCH
  - ALUOp=10 (beq) or 11 (bne), pc_src=1.
  - pc_write = (beq & alu_zero) | (bne & ~alu_zero).
  - Go to FETCH.
- JUMP: pc_write=1, pc_src=2. For jal also RegWrite=1, Jal=1. Go to FETCH.
- JREG: pc_write=1, pc_src=3. For jalr also RegWrite=1, Jal=1. Go to FETCH.
- Memory wait counter
  - 8-bit counter, cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states with mem_ready=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0: next state FAULT.
  - mem_ready arriving on that same cycle wins: normal transition, no fault.
- FAULT: fault=1, all other outputs 0. Exit only by rst.
- mem_ready is ignored in every state other than FETCH/MEM_RD/MEM_WR.
- CPI: R/I-ALU=4, lw/lh=5, sw/sh=4, branch/jump=3, with zero memory wait.

Test Plan:
- rst high 2 cycles, then add $3,$1,$2 (op 0, funct 0x20) with mem_ready=1 every cycle -> states 0,1,2,3,0. ALUOp=1 in EXEC/WB_ALU. RegWrite=1 only in cycle 4. All outputs 0 during reset.
- lh (op 0x21), mem_ready low 3 cycles in MEM_RD -> stays in state 5 for 4 cycles with mem_read=1, i_or_d=1, Half=1. WB_MEM asserts RegWrite=1, MemtoReg=1, Half=1.
- beq with alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH. bne with alu_zero=1 -> pc_write=0. Both return to FETCH after 3 cycles.
- jalr (op 0, funct 0x09) -> JREG with pc_write=1, pc_src=3, RegWrite=1, Jal=1. jal (op 0x03) -> JUMP with pc_src=2, Jal=1.
- opcode 0x3F -> illegal pulses exactly 1 cycle in DECODE. Next state FETCH; no RegWrite or mem_write at any point.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 cycles, fault=1 sticky. Repeat with mem_ready=1 on the 4th cycle -> no fault. rst clears fault.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle sequencer and the shared-memory MIPS datapath.
// The controller side is the master; the datapath side is the slave.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       alu_zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] ALUOp;
    logic       Reg_imm;
    logic       RegWrite;
    logic       MemtoReg;
    logic       Jal;
    logic       Half;
    logic       illegal;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, funct, mem_ready, alu_zero,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, ALUOp,
               Reg_imm, RegWrite, MemtoReg, Jal, Half, illegal, fault, state
    );

    modport slave (
        output opcode, funct, mem_ready, alu_zero,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, ALUOp,
               Reg_imm, RegWrite, MemtoReg, Jal, Half, illegal, fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a MIPS subset sharing one memory port.
// Memory handshake: a request (mem_read/mem_write) is held until mem_ready=1 completes it that cycle.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_WB_ALU = 4'd3;
    localparam logic [3:0] S_ADDR   = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_WB_MEM = 4'd6;
    localparam logic [3:0] S_MEM_WR = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_JREG   = 4'd10;
    localparam logic [3:0] S_FAULT  = 4'd15;

    localparam logic [3:0] C_RALU  = 4'd0;
    localparam logic [3:0] C_IALU  = 4'd1;
    localparam logic [3:0] C_LOAD  = 4'd2;
    localparam logic [3:0] C_STORE = 4'd3;
    localparam logic [3:0] C_BEQ   = 4'd4;
    localparam logic [3:0] C_BNE   = 4'd5;
    localparam logic [3:0] C_J     = 4'd6;
    localparam logic [3:0] C_JAL   = 4'd7;
    localparam logic [3:0] C_JR    = 4'd8;
    localparam logic [3:0] C_JALR  = 4'd9;
    localparam logic [3:0] C_ILL   = 4'd15;

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [3:0] r_state;
    logic [3:0] r_cls;
    logic [3:0] r_alu;
    logic       r_half;
    logic [7:0] r_wait_cnt;

    logic [3:0] w_cls;
    logic [3:0] w_alu;
    logic       w_half;
    logic [3:0] w_next;
    logic       w_mem_wait;
    logic       w_timeout;

    always_comb begin
        w_cls  = C_ILL;
        w_alu  = 4'd0;
        w_half = 1'b0;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20: begin w_cls = C_RALU; w_alu = 4'd1; end
                    6'h22: begin w_cls = C_RALU; w_alu = 4'd2; end
                    6'h24: begin w_cls = C_RALU; w_alu = 4'd3; end
                    6'h25: begin w_cls = C_RALU; w_alu = 4'd4; end
                    6'h26: begin w_cls = C_RALU; w_alu = 4'd5; end
                    6'h27: begin w_cls = C_RALU; w_alu = 4'd6; end
                    6'h2A: begin w_cls = C_RALU; w_alu = 4'd7; end
                    6'h00: begin w_cls = C_RALU; w_alu = 4'd8; end
                    6'h02: begin w_cls = C_RALU; w_alu = 4'd9; end
                    6'h08: w_cls = C_JR;
                    6'h09: w_cls = C_JALR;
                    default: w_cls = C_ILL;
                endcase
            end
            6'h08: begin w_cls = C_IALU; w_alu = 4'd1; end
            6'h0C: begin w_cls = C_IALU; w_alu = 4'd3; end
            6'h0A: begin w_cls = C_IALU; w_alu = 4'd7; end
            6'h23: w_cls = C_LOAD;
            6'h21: begin w_cls = C_LOAD; w_half = 1'b1; end
            6'h2B: w_cls = C_STORE;
            6'h29: begin w_cls = C_STORE; w_half = 1'b1; end
            6'h04: w_cls = C_BEQ;
            6'h05: w_cls = C_BNE;
            6'h02: w_cls = C_J;
            6'h03: w_cls = C_JAL;
            default: w_cls = C_ILL;
        endcase
    end

    // A completing access on the last allowed wait cycle takes priority over the timeout.
    assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout  = w_mem_wait && !bus.mem_ready && (r_wait_cnt == LAST_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : (w_timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (w_cls)
                    C_RALU, C_IALU: w_next = S_EXEC;
                    C_LOAD, C_STORE: w_next = S_ADDR;
                    C_BEQ, C_BNE:   w_next = S_BRANCH;
                    C_J, C_JAL:     w_next = S_JUMP;
                    C_JR, C_JALR:   w_next = S_JREG;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_EXEC:   w_next = S_WB_ALU;
            S_WB_ALU: w_next = S_FETCH;
            S_ADDR:   w_next = (r_cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: w_next = bus.mem_ready ? S_WB_MEM : (w_timeout ? S_FAULT : S_MEM_RD);
            S_WB_MEM: w_next = S_FETCH;
            S_MEM_WR: w_next = bus.mem_ready ? S_FETCH : (w_timeout ? S_FAULT : S_MEM_WR);
            S_BRANCH, S_JUMP, S_JREG: w_next = S_FETCH;
            default:  w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_cls      <= 4'd0;
            r_alu      <= 4'd0;
            r_half     <= 1'b0;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_mem_wait && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (r_state == S_DECODE) begin
                r_cls  <= w_cls;
                r_alu  <= w_alu;
                r_half <= w_half;
            end
        end
    end

    always_comb begin
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'd0;
        bus.ir_write  = 1'b0;
        bus.i_or_d    = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.ALUOp     = 4'd0;
        bus.Reg_imm   = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemtoReg  = 1'b0;
        bus.Jal       = 1'b0;
        bus.Half      = 1'b0;
        bus.illegal   = 1'b0;
        bus.fault     = 1'b0;
        bus.state     = 4'd0;
        if (!rst) begin
            bus.state = r_state;
            case (r_state)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                S_DECODE: bus.illegal = (w_cls == C_ILL);
                S_EXEC, S_WB_ALU: begin
                    bus.ALUOp    = r_alu;
                    bus.Reg_imm  = (r_cls == C_IALU);
                    bus.RegWrite = (r_state == S_WB_ALU);
                end
                S_ADDR: begin
                    bus.ALUOp   = 4'd1;
                    bus.Reg_imm = 1'b1;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                    bus.Half     = r_half;
                end
                S_WB_MEM: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                    bus.Half     = r_half;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                    bus.Half      = r_half;
                end
                S_BRANCH: begin
                    bus.ALUOp    = (r_cls == C_BEQ) ? 4'd10 : 4'd11;
                    bus.pc_src   = 2'd1;
                    bus.pc_write = (r_cls == C_BEQ) ? bus.alu_zero : !bus.alu_zero;
                end
                S_JUMP, S_JREG: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = (r_state == S_JUMP) ? 2'd2 : 2'd3;
                    bus.RegWrite = (r_cls == C_JAL) || (r_cls == C_JALR);
                    bus.Jal      = (r_cls == C_JAL) || (r_cls == C_JALR);
                end
                S_FAULT: bus.fault = 1'b1;
                default: bus.state = r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a per-cycle expected control
// vector is queued by the driver from an instruction-level model and checked by a monitor.
module tb_multicycle_controller;
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
        logic       reg_imm;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
        logic       half;
        logic       illegal;
        logic       fault;
        logic [3:0] state;
    } ctl_t;

    localparam int W = $bits(ctl_t);
    localparam int TIMEOUT = 4;

    localparam int K_ILL = 0, K_RALU = 1, K_IALU = 2, K_LD = 3, K_ST = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_JALR = 10;

    logic clk;
    logic rst;
    logic mon_en;
    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    int cyc_no;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction-level reference: mnemonic class, ALU operation, immediate and halfword flags
    function automatic void decode_model(input logic [5:0] op, input logic [5:0] fn,
                                         output int k, output logic [3:0] alu,
                                         output logic imm, output logic half);
        k = K_ILL; alu = 4'd0; imm = 1'b0; half = 1'b0;
        if (op == 6'h00) begin
            k = K_RALU;
            case (fn)
                6'h20: alu = 4'd1;  // add
                6'h22: alu = 4'd2;  // sub
                6'h24: alu = 4'd3;  // and
                6'h25: alu = 4'd4;  // or
                6'h26: alu = 4'd5;  // xor
                6'h27: alu = 4'd6;  // nor
                6'h2A: alu = 4'd7;  // slt
                6'h00: alu = 4'd8;  // sll
                6'h02: alu = 4'd9;  // srl
                6'h08: k = K_JR;
                6'h09: k = K_JALR;
                default: k = K_ILL;
            endcase
        end else begin
            case (op)
                6'h08: begin k = K_IALU; alu = 4'd1; imm = 1'b1; end
                6'h0C: begin k = K_IALU; alu = 4'd3; imm = 1'b1; end
                6'h0A: begin k = K_IALU; alu = 4'd7; imm = 1'b1; end
                6'h23: k = K_LD;
                6'h21: begin k = K_LD; half = 1'b1; end
                6'h2B: k = K_ST;
                6'h29: begin k = K_ST; half = 1'b1; end
                6'h04: k = K_BEQ;
                6'h05: k = K_BNE;
                6'h02: k = K_J;
                6'h03: k = K_JAL;
                default: k = K_ILL;
            endcase
        end
    endfunction

    function automatic ctl_t st(input logic [3:0] s);
        ctl_t e;
        e = '0;
        e.state = s;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // driver tasks: apply one cycle of inputs and queue the control vector expected for it
    task automatic cyc(input logic r, input logic rdy, input logic z, input ctl_t e);
        rst = r;
        bus.mem_ready = rdy;
        bus.alu_zero = z;
        exp_q.push_back(W'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, rb(), rb(), '0);
    endtask

    task automatic mem_phase(input logic [3:0] s, input int waits, input logic rd,
                             input logic wr, input logic irw, input logic half);
        ctl_t e;
        e = st(s);
        e.mem_read = rd;
        e.mem_write = wr;
        e.i_or_d = (s != 4'd0);
        e.half = half;
        for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, rb(), e);
        e.ir_write = irw;
        e.pc_write = irw;
        cyc(1'b0, 1'b1, rb(), e);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input int zf);
        int k;
        logic [3:0] alu;
        logic imm, half, z;
        ctl_t e;
        decode_model(op, fn, k, alu, imm, half);
        bus.opcode = op;
        bus.funct = fn;
        mem_phase(4'd0, fw, 1'b1, 1'b0, 1'b1, 1'b0);
        e = st(4'd1);
        e.illegal = (k == K_ILL);
        cyc(1'b0, rb(), rb(), e);
        if (k == K_RALU || k == K_IALU) begin
            e = st(4'd2); e.alu_op = alu; e.reg_imm = imm;
            cyc(1'b0, rb(), rb(), e);
            e.state = 4'd3; e.reg_write = 1'b1;
            cyc(1'b0, rb(), rb(), e);
        end else if (k == K_LD || k == K_ST) begin
            e = st(4'd4); e.alu_op = 4'd1; e.reg_imm = 1'b1;
            cyc(1'b0, rb(), rb(), e);
            if (k == K_LD) begin
                mem_phase(4'd5, mw, 1'b1, 1'b0, 1'b0, half);
                e = st(4'd6); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.half = half;
                cyc(1'b0, rb(), rb(), e);
            end else begin
                mem_phase(4'd7, mw, 1'b0, 1'b1, 1'b0, half);
            end
        end else if (k == K_BEQ || k == K_BNE) begin
            z = (zf < 0) ? rb() : 1'(zf);
            e = st(4'd8); e.pc_src = 2'd1;
            e.alu_op = (k == K_BEQ) ? 4'd10 : 4'd11;
            e.pc_write = (k == K_BEQ) ? z : !z;
            cyc(1'b0, rb(), z, e);
        end else if (k != K_ILL) begin
            e = st((k == K_J || k == K_JAL) ? 4'd9 : 4'd10);
            e.pc_write = 1'b1;
            e.pc_src = (k == K_J || k == K_JAL) ? 2'd2 : 2'd3;
            e.reg_write = (k == K_JAL || k == K_JALR);
            e.jal = (k == K_JAL || k == K_JALR);
            cyc(1'b0, rb(), rb(), e);
        end
    endtask

    // stalls an access of the given phase past the limit, then sits in the trap state
    task automatic run_fault(input logic in_mem);
        ctl_t e;
        bus.opcode = in_mem ? 6'h23 : 6'h00;
        bus.funct = 6'h20;
        if (in_mem) begin
            mem_phase(4'd0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, rb(), rb(), st(4'd1));
            e = st(4'd4); e.alu_op = 4'd1; e.reg_imm = 1'b1;
            cyc(1'b0, rb(), rb(), e);
            e = st(4'd5); e.mem_read = 1'b1; e.i_or_d = 1'b1;
        end else begin
            e = st(4'd0); e.mem_read = 1'b1;
        end
        for (int i = 0; i < TIMEOUT; i++) cyc(1'b0, 1'b0, rb(), e);
        e = st(4'd15);
        e.fault = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b0, rb(), rb(), e);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            ctl_t a;
            logic [W-1:0] x;
            a.pc_write = bus.pc_write;     a.pc_src = bus.pc_src;
            a.ir_write = bus.ir_write;     a.i_or_d = bus.i_or_d;
            a.mem_read = bus.mem_read;     a.mem_write = bus.mem_write;
            a.alu_op = bus.ALUOp;          a.reg_imm = bus.Reg_imm;
            a.reg_write = bus.RegWrite;    a.mem_to_reg = bus.MemtoReg;
            a.jal = bus.Jal;               a.half = bus.Half;
            a.illegal = bus.illegal;       a.fault = bus.fault;
            a.state = bus.state;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_underflow cycle %0d actual=%h", cyc_no, W'(a));
            end else begin
                x = exp_q.pop_front();
                if (W'(a) !== x) begin
                    errors++;
                    $display("FAIL ctl cycle %0d actual=%h expected=%h", cyc_no, W'(a), x);
                end
            end
            cyc_no++;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog expired actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [5:0] ops[22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0A, 6'h23, 6'h21,
                                6'h2B, 6'h29, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [5:0] fns[11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
                                6'h02, 6'h08, 6'h09};
        int idx;
        logic [5:0] op, fn;
        checks = 0; errors = 0; cyc_no = 0; mon_en = 1'b0;
        rst = 1'b1; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        do_reset(2);
        run_instr(6'h00, 6'h20, 0, 0, -1);   // add
        run_instr(6'h21, 6'h15, 0, 3, -1);   // lh with three stalled cycles
        run_instr(6'h04, 6'h00, 0, 0, 1);    // beq taken
        run_instr(6'h05, 6'h00, 0, 0, 1);    // bne not taken
        run_instr(6'h00, 6'h09, 0, 0, -1);   // jalr
        run_instr(6'h03, 6'h2A, 0, 0, -1);   // jal
        run_instr(6'h3F, 6'h20, 0, 0, -1);   // undecodable
        run_instr(6'h00, 6'h3F, 0, 0, -1);   // unknown funct
        run_instr(6'h2B, 6'h00, TIMEOUT - 1, TIMEOUT - 1, -1);  // ready on the last allowed cycle
        run_fault(1'b0);
        do_reset(1);
        run_instr(6'h08, 6'h00, 1, 0, -1);
        run_fault(1'b1);
        do_reset(2);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                fn = 6'($urandom_range(0, 63));
            end else begin
                idx = $urandom_range(0, 21);
                op = ops[idx];
                fn = (idx < 11) ? fns[idx] : 6'($urandom_range(0, 63));
            end
            run_instr(op, fn, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), -1);
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
